// File: rtl/sprite_scheduler_if.sv
// Draw-descriptor channel between the sprite scheduler (master) and the vector draw engine (slave).
interface sprite_scheduler_if #(
  parameter int W     = 8,
  parameter int ADR_W = 10
);
  logic             draw_valid;
  logic             draw_ready;
  logic [ADR_W-1:0] draw_adr;
  logic [W-1:0]     draw_x;
  logic [W-1:0]     draw_y;
  logic             draw_done;

  modport master (
    output draw_valid, draw_adr, draw_x, draw_y,
    input  draw_ready, draw_done
  );

  modport slave (
    input  draw_valid, draw_adr, draw_x, draw_y,
    output draw_ready, draw_done
  );
endinterface

// File: rtl/sprite_scheduler.sv
// Runtime sprite/image tables plus a per-frame draw sequencer feeding the vector draw engine.
// Optional macro SPRITE_ORIGIN_CLAMP_EN: clamp origin subtraction to 0..2^W-1 instead of wrapping.
module sprite_scheduler #(
  parameter int N_SPRITES = 8,
  parameter int N_IMG     = 16,
  parameter int W         = 8,
  parameter int ADR_W     = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         img_we,
  input  logic [$clog2(N_IMG)-1:0]     img_idx,
  input  logic [ADR_W-1:0]             img_adr,
  input  logic [W-1:0]                 img_mid_x,
  input  logic [W-1:0]                 img_mid_y,
  input  logic                         spr_we,
  input  logic [$clog2(N_SPRITES)-1:0] spr_idx,
  input  logic                         spr_en,
  input  logic [$clog2(N_IMG)-1:0]     spr_img,
  input  logic [W-1:0]                 spr_x,
  input  logic [W-1:0]                 spr_y,
  input  logic                         frame_start,
  sprite_scheduler_if.master           draw,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         frame_overrun
);

  localparam int SW = $clog2(N_SPRITES);
  localparam int IW = $clog2(N_IMG);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_DONE, DONE} state_t;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [W-1:0]     mid_x;
    logic [W-1:0]     mid_y;
  } img_t;

  typedef struct packed {
    logic          en;
    logic [IW-1:0] img;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
  } spr_t;

  img_t   img_tab [N_IMG];
  spr_t   spr_tab [N_SPRITES];
  state_t state, state_nxt;
  logic [SW-1:0]    idx;
  logic [ADR_W-1:0] adr_q;
  logic [W-1:0]     x_q, y_q;
  spr_t cur_spr;
  img_t cur_img;
  logic last;

  function automatic logic [W-1:0] origin(input logic [W-1:0] pos, input logic [W-1:0] mid);
`ifdef SPRITE_ORIGIN_CLAMP_EN
    logic signed [W:0] d;
    d = $signed({1'b0, pos}) - $signed({1'b0, mid});
    if (d < 0) return '0;
    if (d > $signed({1'b0, {W{1'b1}}})) return '1;
    return d[W-1:0];
`else
    return pos - mid;
`endif
  endfunction

  // NOTE: the tables are reset explicitly because a disabled, zeroed table is the defined post-reset state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IMG; i++)     img_tab[i] <= '0;
      for (int i = 0; i < N_SPRITES; i++) spr_tab[i] <= '0;
    end else begin
      if (img_we && int'(img_idx) < N_IMG)
        img_tab[img_idx] <= '{adr: img_adr, mid_x: img_mid_x, mid_y: img_mid_y};
      if (spr_we && int'(spr_idx) < N_SPRITES)
        spr_tab[spr_idx] <= '{en: spr_en, img: spr_img, x: spr_x, y: spr_y};
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cur_spr = spr_tab[idx];
    cur_img = '0;
    if (int'(cur_spr.img) < N_IMG) cur_img = img_tab[cur_spr.img];
    last = (idx == SW'(N_SPRITES - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (frame_start) state_nxt = FETCH;
      FETCH:     if (cur_spr.en) state_nxt = ISSUE;
                 else if (last)  state_nxt = DONE;
      ISSUE:     if (draw.draw_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (draw.draw_done) state_nxt = last ? DONE : FETCH;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    draw.draw_valid = (state == ISSUE);
    busy            = (state != IDLE);
    frame_done      = (state == DONE);
    frame_overrun   = frame_start && (state != IDLE);
  end

  // Descriptor is captured once in FETCH, so later table writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      adr_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      case (state)
        IDLE: if (frame_start) idx <= '0;
        FETCH:
          if (cur_spr.en) begin
            adr_q <= cur_img.adr;
            x_q   <= origin(cur_spr.x, cur_img.mid_x);
            y_q   <= origin(cur_spr.y, cur_img.mid_y);
          end else if (!last) begin
            idx <= idx + 1'b1;
          end
        WAIT_DONE: if (draw.draw_done && !last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign draw.draw_adr = adr_q;
  assign draw.draw_x   = x_q;
  assign draw.draw_y   = y_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed self-checking bench for sprite_scheduler (default 8 slots, 16 images, W=8, ADR_W=10).
module tb_sprite_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       img_we, spr_we, spr_en, frame_start;
  logic [3:0] img_idx, spr_img;
  logic [2:0] spr_idx;
  logic [9:0] img_adr;
  logic [7:0] img_mid_x, img_mid_y, spr_x, spr_y;
  logic       busy, frame_done, frame_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int q_adr[$], q_x[$], q_y[$];

  sprite_scheduler_if #(.W(8), .ADR_W(10)) dif ();

  sprite_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .img_we(img_we), .img_idx(img_idx), .img_adr(img_adr),
    .img_mid_x(img_mid_x), .img_mid_y(img_mid_y),
    .spr_we(spr_we), .spr_idx(spr_idx), .spr_en(spr_en), .spr_img(spr_img),
    .spr_x(spr_x), .spr_y(spr_y),
    .frame_start(frame_start), .draw(dif),
    .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_img(input int i, input int adr, input int mx, input int my);
    img_we = 1'b1; img_idx = 4'(i); img_adr = 10'(adr); img_mid_x = 8'(mx); img_mid_y = 8'(my);
    tick();
    img_we = 1'b0;
  endtask

  task automatic write_spr(input int i, input bit en, input int img, input int x, input int y);
    spr_we = 1'b1; spr_idx = 3'(i); spr_en = en; spr_img = 4'(img); spr_x = 8'(x); spr_y = 8'(y);
    tick();
    spr_we = 1'b0;
  endtask

  // Plays the draw engine for one frame; descriptors land in q_adr/q_x/q_y.
  task automatic serve_frame(input int rdy_delay, input int done_delay,
                             output int n, output bit proto_err, output bit timeout);
    int stall;
    int ha, hx, hy;
    n = 0; proto_err = 1'b0; timeout = 1'b1; stall = 0;
    ha = 0; hx = 0; hy = 0;
    for (int c = 0; c < 400; c++) begin
      if (frame_done) begin
        timeout = 1'b0;
        break;
      end
      if (dif.draw_valid) begin
        if (stall == 0) begin
          ha = int'(dif.draw_adr); hx = int'(dif.draw_x); hy = int'(dif.draw_y);
        end else if (int'(dif.draw_adr) != ha || int'(dif.draw_x) != hx || int'(dif.draw_y) != hy) begin
          proto_err = 1'b1;
        end
        if (stall >= rdy_delay) begin
          dif.draw_ready = 1'b1;
          tick();
          dif.draw_ready = 1'b0;
          q_adr.push_back(ha); q_x.push_back(hx); q_y.push_back(hy);
          n++;
          if (dif.draw_valid) proto_err = 1'b1;
          repeat (done_delay) tick();
          dif.draw_done = 1'b1;
          tick();
          dif.draw_done = 1'b0;
          stall = 0;
        end else begin
          stall++;
          tick();
        end
      end else begin
        tick();
      end
    end
  endtask

  task automatic start_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n, fd_cnt;
    bit  perr, tmo;
    int  exp_x, exp_y;

    rst_n = 1'b0; img_we = 0; spr_we = 0; spr_en = 0; frame_start = 0;
    img_idx = 0; spr_idx = 0; spr_img = 0; img_adr = 0;
    img_mid_x = 0; img_mid_y = 0; spr_x = 0; spr_y = 0;
    dif.draw_ready = 1'b0; dif.draw_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", dif.draw_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_ovr", frame_overrun, 0);
    check("rst_adr", dif.draw_adr, 0);
    check("rst_xy", {dif.draw_x, dif.draw_y}, 0);

    // Basic draw
    write_img(0, 349, 128, 128);
    write_spr(0, 1, 0, 128, 128);
    q_adr.delete(); q_x.delete(); q_y.delete();
    start_frame();
    check("basic_busy_k1", busy, 1);
    check("basic_valid_k1", dif.draw_valid, 0);
    serve_frame(0, 3, n, perr, tmo);
    check("basic_timeout", tmo, 0);
    check("basic_count", n, 1);
    check("basic_proto", perr, 0);
    if (n == 1) begin
      check("basic_adr", q_adr[0], 349);
      check("basic_x", q_x[0], 0);
      check("basic_y", q_y[0], 0);
    end
    tick();
    check("basic_idle", busy, 0);

    // Wrap vs clamp
    write_spr(0, 0, 0, 128, 128);
    write_img(1, 517, 32, 40);
    write_spr(2, 1, 1, 15, 20);
`ifdef SPRITE_ORIGIN_CLAMP_EN
    exp_x = 0;   exp_y = 0;
`else
    exp_x = 239; exp_y = 236;
`endif
    q_adr.delete(); q_x.delete(); q_y.delete();
    start_frame();
    serve_frame(1, 1, n, perr, tmo);
    check("wrap_timeout", tmo, 0);
    check("wrap_count", n, 1);
    if (n == 1) begin
      check("wrap_adr", q_adr[0], 517);
      check("wrap_x", q_x[0], exp_x);
      check("wrap_y", q_y[0], exp_y);
    end
    tick();

    // Backpressure and order
    write_spr(2, 0, 0, 0, 0);
    write_img(2, 100, 0, 0);
    write_img(3, 200, 0, 0);
    write_img(4, 300, 0, 0);
    write_spr(1, 1, 2, 10, 11);
    write_spr(5, 1, 3, 50, 51);
    write_spr(7, 1, 4, 70, 71);
    q_adr.delete(); q_x.delete(); q_y.delete();
    start_frame();
    serve_frame(4, 2, n, perr, tmo);
    check("bp_timeout", tmo, 0);
    check("bp_count", n, 3);
    check("bp_stable", perr, 0);
    if (n == 3) begin
      check("bp_adr0", q_adr[0], 100);
      check("bp_adr1", q_adr[1], 200);
      check("bp_adr2", q_adr[2], 300);
      check("bp_x0", q_x[0], 10);
      check("bp_y2", q_y[2], 71);
    end
    tick();

    // Empty frame and overrun
    write_spr(1, 0, 0, 0, 0);
    write_spr(5, 0, 0, 0, 0);
    write_spr(7, 0, 0, 0, 0);
    start_frame();
    for (int j = 1; j <= 10; j++) begin
      frame_start = (j == 3);
      #1;
      check($sformatf("empty_busy_%0d", j), busy, (j <= 9) ? 1 : 0);
      check($sformatf("empty_fdone_%0d", j), frame_done, (j == 9) ? 1 : 0);
      check($sformatf("empty_ovr_%0d", j), frame_overrun, (j == 3) ? 1 : 0);
      frame_start = 1'b0;
      tick();
    end

    // Write during scan
    write_spr(0, 1, 0, 128, 128);
    start_frame();
    tick();
    check("wds_valid", dif.draw_valid, 1);
    spr_we = 1'b1; spr_idx = 3'd0; spr_en = 1'b1; spr_img = 4'd0; spr_x = 8'd138; spr_y = 8'd128;
    tick();
    spr_we = 1'b0;
    check("wds_still_valid", dif.draw_valid, 1);
    check("wds_x_held", dif.draw_x, 0);
    dif.draw_ready = 1'b1;
    tick();
    dif.draw_ready = 1'b0;
    check("wds_valid_drop", dif.draw_valid, 0);
    dif.draw_done = 1'b1;
    tick();
    dif.draw_done = 1'b0;
    serve_frame(0, 0, n, perr, tmo);
    check("wds_rest_count", n, 0);
    check("wds_rest_timeout", tmo, 0);
    tick();
    q_adr.delete(); q_x.delete(); q_y.delete();
    start_frame();
    serve_frame(0, 1, n, perr, tmo);
    check("wds_next_count", n, 1);
    if (n == 1) check("wds_next_x", q_x[0], 10);
    tick();

    // Reset mid-scan
    start_frame();
    tick();
    dif.draw_ready = 1'b1;
    tick();
    dif.draw_ready = 1'b0;
    check("rms_busy_wait", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rms_valid", dif.draw_valid, 0);
    check("rms_busy", busy, 0);
    check("rms_adr", dif.draw_adr, 0);
    fd_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      if (frame_done) fd_cnt++;
      tick();
    end
    check("rms_no_fdone", fd_cnt, 0);
    start_frame();
    serve_frame(0, 0, n, perr, tmo);
    check("rms_empty_count", n, 0);
    check("rms_empty_timeout", tmo, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Parametrised runtime sprite table and draw sequencer for the vector display path. Image geometry (ROM start address, mid-point X/Y) and per-sprite state (enable, image select, screen position) are held in writable register tables instead of fixed constants. On each frame start the block walks all sprite slots in index order. For every enabled slot it issues one draw descriptor (ROM address plus top-left origin) to the vector draw engine, using a valid/ready handshake followed by a done acknowledge.

## Interface
Parameters:
- N_SPRITES, 8, number of sprite slots (2..64)
- N_IMG, 16, number of image descriptor entries (2..64)
- W, 8, coordinate width (screen 0..2^W-1)
- ADR_W, 10, ROM address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- img_we  in  1  image table write strobe
- img_idx  in  clog2(N_IMG)  image entry index
- img_adr  in  ADR_W  image ROM start address
- img_mid_x, img_mid_y  in  W  image mid-point
- spr_we  in  1  sprite table write strobe
- spr_idx  in  clog2(N_SPRITES)  sprite slot index
- spr_en  in  1  slot enable
- spr_img  in  clog2(N_IMG)  image select
- spr_x, spr_y  in  W  sprite centre position
- frame_start  in  1  one-cycle pulse; begins a scan
- draw_valid  out  1  descriptor valid
- draw_ready  in  1  draw engine accepts descriptor
- draw_adr  out  ADR_W  ROM start address
- draw_x, draw_y  out  W  drawing origin
- draw_done  in  1  draw engine finished current sprite
- busy  out  1  scan in progress
- frame_done  out  1  one-cycle pulse at end of scan
- frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy

## Operation
- Tables are registered. Writes take effect at the clock edge.
- A fetch in the same cycle as a write to the same entry reads the old value.
- Out-of-range indices on writes are ignored.
- FSM states: IDLE, FETCH, ISSUE, WAIT_DONE, DONE.
- IDLE:
  - frame_start=1 -> FETCH with slot index 0.
  - Otherwise stay in IDLE.
- FETCH (one cycle), reads slot[idx]:
  - Enabled: register draw_adr=img[spr_img].adr, draw_x=spr_x−mid_x, draw_y=spr_y−mid_y -> ISSUE.
  - Disabled and idx<N_SPRITES−1: idx+1, remain in FETCH.
  - Disabled and idx is last: -> DONE.
- ISSUE: draw_valid=1 and outputs held stable. When draw_valid&&draw_ready -> WAIT_DONE.
- WAIT_DONE: draw_done=1 -> idx+1 and FETCH, or DONE if idx is last. draw_done is ignored in every other state.
- DONE: frame_done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- frame_start while busy: scan continues unaffected and frame_overrun pulses in the same cycle.
- Table writes during a scan are allowed. A descriptor latched in FETCH is unaffected by later writes.
- Arithmetic: origin subtraction is W-bit; default behaviour is modulo 2^W wrap (see Configuration).

## Timing
- Reset values (rst_n=0 at an edge):
  - state IDLE, idx 0.
  - All sprite slots disabled with image 0 and position 0. All image entries zero.
  - draw_valid, busy, frame_done, frame_overrun 0. draw_adr, draw_x, draw_y 0.
- Reset mid-scan aborts immediately. No frame_done is produced.
- frame_start sampled at edge k -> FETCH in cycle k+1, busy=1 from k+1.
- Enabled slot: draw_valid rises one cycle after its FETCH cycle.
- After an accepted handshake, draw_valid drops the next cycle.
- After draw_done, the next FETCH happens the following cycle.
- Empty frame (all disabled) with N_SPRITES=8: FETCH k+1..k+8, frame_done=1 in k+9, busy=0 from k+10.
- Per enabled sprite overhead: 1 FETCH + ≥1 ISSUE + ≥1 WAIT_DONE cycles.

## Configuration
- SPRITE_ORIGIN_CLAMP_EN defined:
  - Origin subtraction is performed at W+1 bits signed.
  - Negative results clamp to 0.
  - Results > 2^W−1 clamp to 2^W−1.
- Undefined: plain modulo 2^W wrap.

## Test plan
- Basic draw:
  - Stimulus: img0={349,128,128}; slot0 enabled, img0, pos (128,128); others disabled; frame_start; draw_ready=1; draw_done 3 cycles after accept.
  - Response: exactly one descriptor adr=349, x=0, y=0; then frame_done.
- Wrap vs clamp:
  - Stimulus: img1={517,32,40}; slot2 at (15,20).
  - Response without macro: x=239, y=236. With SPRITE_ORIGIN_CLAMP_EN: x=0, y=0.
- Backpressure and order:
  - Stimulus: slots 1, 5, 7 enabled with distinct images; draw_ready low for 4 cycles per descriptor.
  - Response: descriptors emitted in order 1, 5, 7; outputs stable while valid&&!ready; one transfer each.
- Empty frame and overrun:
  - Stimulus: all slots disabled; frame_start at k, second frame_start at k+3.
  - Response: frame_overrun at k+3 only; frame_done at k+9.
- Write during scan:
  - Stimulus: rewrite slot 0 x while in ISSUE for slot 0.
  - Response: current descriptor unchanged; new value used next frame.
- Reset mid-scan:
  - Stimulus: rst_n=0 while in WAIT_DONE.
  - Response: draw_valid=0, busy=0, no frame_done; slots disabled; a following frame_start gives an empty frame.
